// File: rtl/debug_reg_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// debug_reg_sequencer_pkg
//
// Shared definitions for the AAP register-file debug sequencer:
//   - processor state code that means "halted"
//   - debug request command codes
//   - sequencer FSM state encodings
//   - small helper to classify single-register commands
// ----------------------------------------------------------------------------
package debug_reg_sequencer_pkg;

   // Processor state value that permits debug access to the register file.
   localparam logic [2:0] STATE_HALTED = 3'd2;

   // Debug request commands as carried on req_cmd.
   typedef enum logic [1:0] {
      DBG_CMD_READ  = 2'd0,
      DBG_CMD_WRITE = 2'd1,
      DBG_CMD_DUMP  = 2'd2,
      DBG_CMD_CLEAR = 2'd3
   } dbg_cmd_e;

   // Sequencer FSM states.
   typedef enum logic [2:0] {
      DRS_IDLE  = 3'd0,
      DRS_READ  = 3'd1,
      DRS_WRITE = 3'd2,
      DRS_DUMP  = 3'd3,
      DRS_CLEAR = 3'd4,
      DRS_RESP  = 3'd5
   } drs_state_e;

   // READ and WRITE address a single register and therefore need a
   // register-number range check; DUMP and CLEAR walk the whole file.
   function automatic logic is_single_cmd(input logic [1:0] cmd);
      return (cmd == DBG_CMD_READ) || (cmd == DBG_CMD_WRITE);
   endfunction

endpackage

// File: rtl/debug_reg_sequencer.sv
// ----------------------------------------------------------------------------
// debug_reg_sequencer
//
// Sole master of the AAP register file debug port. Accepts READ, WRITE,
// DUMP and CLEAR requests over a valid/ready handshake, refuses them unless
// the processor is halted, performs one register-file access per cycle and
// returns results over a valid/ready response channel.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   state                 processor state (compared against STATE_HALTED)
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_cmd               0 READ, 1 WRITE, 2 DUMP, 3 CLEAR
//   req_regnum/req_wdata  target register and write data
//   rsp_valid/rsp_ready   response handshake
//   rsp_data              read data, echoed write data, or 0 on error
//   rsp_regnum            register the beat refers to
//   rsp_last              final beat of the request
//   rsp_err               request rejected or aborted
//   dbg_reg_rregnum       register file read address
//   dbg_reg_rdata         register file read data (combinational)
//   dbg_reg_wregnum/wdata register file write address/data
//   dbg_reg_we            register file write enable
//   busy                  sequencer not idle
// ----------------------------------------------------------------------------
module debug_reg_sequencer
   import debug_reg_sequencer_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int REGNUM_W = 6,
   parameter int DATA_W   = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [2:0]          state,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [1:0]          req_cmd,
   input  logic [REGNUM_W-1:0] req_regnum,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_data,
   output logic [REGNUM_W-1:0] rsp_regnum,
   output logic                rsp_last,
   output logic                rsp_err,
   output logic [REGNUM_W-1:0] dbg_reg_rregnum,
   input  logic [DATA_W-1:0]   dbg_reg_rdata,
   output logic [REGNUM_W-1:0] dbg_reg_wregnum,
   output logic [DATA_W-1:0]   dbg_reg_wdata,
   output logic                dbg_reg_we,
   output logic                busy
);

   localparam logic [REGNUM_W-1:0] LAST_IDX = REGNUM_W'(NUM_REGS - 1);
   localparam logic [REGNUM_W:0]   NUM_REGS_EXT = (REGNUM_W + 1)'(NUM_REGS);

   drs_state_e          fsm_r,        fsm_n;
   dbg_cmd_e            cmd_r,        cmd_n;
   logic [REGNUM_W-1:0] idx_r,        idx_n;
   logic [DATA_W-1:0]   wdata_r,      wdata_n;
   logic                rsp_valid_r,  rsp_valid_n;
   logic [DATA_W-1:0]   rsp_data_r,   rsp_data_n;
   logic [REGNUM_W-1:0] rsp_regnum_r, rsp_regnum_n;
   logic                rsp_last_r,   rsp_last_n;
   logic                rsp_err_r,    rsp_err_n;

   logic halted_s;
   logic regnum_ok_s;
   logic reject_s;

   assign halted_s    = (state == STATE_HALTED);
   // Widen by one bit so NUM_REGS == 2**REGNUM_W still compares correctly.
   assign regnum_ok_s = ({1'b0, req_regnum} < NUM_REGS_EXT);
   assign reject_s    = !halted_s || (is_single_cmd(req_cmd) && !regnum_ok_s);

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_r <= DRS_IDLE;
      end else begin
         fsm_r <= fsm_n;
      end
   end

   // Latched request, index counter and response register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_r        <= DBG_CMD_READ;
         idx_r        <= '0;
         wdata_r      <= '0;
         rsp_valid_r  <= 1'b0;
         rsp_data_r   <= '0;
         rsp_regnum_r <= '0;
         rsp_last_r   <= 1'b0;
         rsp_err_r    <= 1'b0;
      end else begin
         cmd_r        <= cmd_n;
         idx_r        <= idx_n;
         wdata_r      <= wdata_n;
         rsp_valid_r  <= rsp_valid_n;
         rsp_data_r   <= rsp_data_n;
         rsp_regnum_r <= rsp_regnum_n;
         rsp_last_r   <= rsp_last_n;
         rsp_err_r    <= rsp_err_n;
      end
   end

   // Next-state logic and next values for the datapath registers.
   always_comb begin
      fsm_n        = fsm_r;
      cmd_n        = cmd_r;
      idx_n        = idx_r;
      wdata_n      = wdata_r;
      rsp_valid_n  = rsp_valid_r;
      rsp_data_n   = rsp_data_r;
      rsp_regnum_n = rsp_regnum_r;
      rsp_last_n   = rsp_last_r;
      rsp_err_n    = rsp_err_r;

      case (fsm_r)
         DRS_IDLE: begin
            if (req_valid) begin
               cmd_n = dbg_cmd_e'(req_cmd);
               if (reject_s) begin
                  // Rejected requests answer immediately without touching
                  // the register file.
                  fsm_n        = DRS_RESP;
                  rsp_valid_n  = 1'b1;
                  rsp_data_n   = '0;
                  rsp_regnum_n = req_regnum;
                  rsp_last_n   = 1'b1;
                  rsp_err_n    = 1'b1;
               end else begin
                  case (req_cmd)
                     DBG_CMD_READ: begin
                        fsm_n = DRS_READ;
                        idx_n = req_regnum;
                     end
                     DBG_CMD_WRITE: begin
                        fsm_n   = DRS_WRITE;
                        idx_n   = req_regnum;
                        wdata_n = req_wdata;
                     end
                     DBG_CMD_DUMP: begin
                        fsm_n = DRS_DUMP;
                        idx_n = '0;
                     end
                     DBG_CMD_CLEAR: begin
                        fsm_n   = DRS_CLEAR;
                        idx_n   = '0;
                        wdata_n = '0;
                     end
                     default: begin
                        fsm_n = DRS_IDLE;
                     end
                  endcase
               end
            end else begin
               fsm_n = DRS_IDLE;
            end
         end

         DRS_READ: begin
            fsm_n        = DRS_RESP;
            rsp_valid_n  = 1'b1;
            rsp_data_n   = dbg_reg_rdata;
            rsp_regnum_n = idx_r;
            rsp_last_n   = 1'b1;
            rsp_err_n    = 1'b0;
         end

         DRS_WRITE: begin
            // The write itself happens this cycle via dbg_reg_we; the
            // response simply echoes what was written.
            fsm_n        = DRS_RESP;
            rsp_valid_n  = 1'b1;
            rsp_data_n   = wdata_r;
            rsp_regnum_n = idx_r;
            rsp_last_n   = 1'b1;
            rsp_err_n    = 1'b0;
         end

         DRS_DUMP: begin
            fsm_n        = DRS_RESP;
            rsp_valid_n  = 1'b1;
            rsp_regnum_n = idx_r;
            if (!halted_s) begin
               // Processor resumed: abort the walk with an error beat.
               rsp_data_n = '0;
               rsp_last_n = 1'b1;
               rsp_err_n  = 1'b1;
            end else begin
               rsp_data_n = dbg_reg_rdata;
               rsp_last_n = (idx_r == LAST_IDX);
               rsp_err_n  = 1'b0;
            end
         end

         DRS_CLEAR: begin
            if (!halted_s) begin
               // Registers already cleared stay cleared; report where we
               // stopped.
               fsm_n        = DRS_RESP;
               rsp_valid_n  = 1'b1;
               rsp_data_n   = '0;
               rsp_regnum_n = idx_r;
               rsp_last_n   = 1'b1;
               rsp_err_n    = 1'b1;
            end else if (idx_r == LAST_IDX) begin
               fsm_n        = DRS_RESP;
               rsp_valid_n  = 1'b1;
               rsp_data_n   = '0;
               rsp_regnum_n = idx_r;
               rsp_last_n   = 1'b1;
               rsp_err_n    = 1'b0;
            end else begin
               fsm_n = DRS_CLEAR;
               idx_n = idx_r + REGNUM_W'(1);
            end
         end

         DRS_RESP: begin
            if (rsp_ready) begin
               rsp_valid_n = 1'b0;
               // Only a DUMP that has not yet produced its last beat loops
               // back; an aborted DUMP has rsp_last set and ends here.
               if ((cmd_r == DBG_CMD_DUMP) && !rsp_last_r) begin
                  fsm_n = DRS_DUMP;
                  idx_n = idx_r + REGNUM_W'(1);
               end else begin
                  fsm_n = DRS_IDLE;
               end
            end else begin
               fsm_n = DRS_RESP;
            end
         end

         default: begin
            fsm_n       = DRS_IDLE;
            rsp_valid_n = 1'b0;
         end
      endcase
   end

   assign req_ready       = (fsm_r == DRS_IDLE);
   assign busy            = (fsm_r != DRS_IDLE);

   assign rsp_valid       = rsp_valid_r;
   assign rsp_data        = rsp_data_r;
   assign rsp_regnum      = rsp_regnum_r;
   assign rsp_last        = rsp_last_r;
   assign rsp_err         = rsp_err_r;

   // The same index addresses both ports: the latched register for
   // READ/WRITE, the walk position for DUMP/CLEAR.
   assign dbg_reg_rregnum = idx_r;
   assign dbg_reg_wregnum = idx_r;
   assign dbg_reg_wdata   = wdata_r;

   // CLEAR writes are gated by the live halted check so that a processor
   // resuming mid-clear stops the write in the very same cycle.
   assign dbg_reg_we      = (fsm_r == DRS_WRITE) ||
                            ((fsm_r == DRS_CLEAR) && halted_s);

endmodule

// File: tb/tb_debug_reg_sequencer.sv
// ----------------------------------------------------------------------------
// tb_debug_reg_sequencer
//
// Directed and randomized bench for debug_reg_sequencer. The bench owns the
// register file (written on dbg_reg_we, read combinationally) and keeps a
// separate reference array of what each register should hold. Latency values
// count clock edges after the accept edge E0 at which the response handshake
// can first complete.
// ----------------------------------------------------------------------------
module tb_debug_reg_sequencer;
   import debug_reg_sequencer_pkg::*;

   localparam int NREG = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  state;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_cmd;
   logic [5:0]  req_regnum;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic [5:0]  rsp_regnum;
   logic        rsp_last;
   logic        rsp_err;
   logic [5:0]  dbg_reg_rregnum;
   logic [15:0] dbg_reg_rdata;
   logic [5:0]  dbg_reg_wregnum;
   logic [15:0] dbg_reg_wdata;
   logic        dbg_reg_we;
   logic        busy;

   int vectors     = 0;
   int miscompares = 0;
   int we_count    = 0;
   int exp_we      = 0;

   logic [15:0] rf     [0:63];
   logic [15:0] ref_rf [0:NREG-1];

   always #5 clk = ~clk;

   debug_reg_sequencer #(
      .NUM_REGS (NREG),
      .REGNUM_W (6),
      .DATA_W   (16)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .state           (state),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_cmd         (req_cmd),
      .req_regnum      (req_regnum),
      .req_wdata       (req_wdata),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_data        (rsp_data),
      .rsp_regnum      (rsp_regnum),
      .rsp_last        (rsp_last),
      .rsp_err         (rsp_err),
      .dbg_reg_rregnum (dbg_reg_rregnum),
      .dbg_reg_rdata   (dbg_reg_rdata),
      .dbg_reg_wregnum (dbg_reg_wregnum),
      .dbg_reg_wdata   (dbg_reg_wdata),
      .dbg_reg_we      (dbg_reg_we),
      .busy            (busy)
   );

   assign dbg_reg_rdata = rf[dbg_reg_rregnum];

   // Register file: one write per cycle on the debug port.
   always @(posedge clk) begin
      if (dbg_reg_we) begin
         rf[dbg_reg_wregnum] <= dbg_reg_wdata;
         we_count            <= we_count + 1;
      end
   end

   // Hard time limit so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".rsp_valid"}, 32'(rsp_valid),       32'd0);
      check({tag, ".rsp_data"},  32'(rsp_data),        32'd0);
      check({tag, ".rsp_regnum"},32'(rsp_regnum),      32'd0);
      check({tag, ".rsp_last"},  32'(rsp_last),        32'd0);
      check({tag, ".rsp_err"},   32'(rsp_err),         32'd0);
      check({tag, ".we"},        32'(dbg_reg_we),      32'd0);
      check({tag, ".rregnum"},   32'(dbg_reg_rregnum), 32'd0);
      check({tag, ".wregnum"},   32'(dbg_reg_wregnum), 32'd0);
      check({tag, ".wdata"},     32'(dbg_reg_wdata),   32'd0);
      check({tag, ".busy"},      32'(busy),            32'd0);
      check({tag, ".req_ready"}, 32'(req_ready),       32'd1);
   endtask

   // Called at a negedge; returns at the negedge after the accept edge E0.
   task automatic send_req(input logic [1:0] c, input logic [5:0] n, input logic [15:0] d);
      check("req_ready", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_cmd    = c;
      req_regnum = n;
      req_wdata  = d;
      @(posedge clk);
      @(negedge clk);
      req_valid  = 1'b0;
      check("busy_after_accept", 32'(busy), 32'd1);
   endtask

   // Called at a negedge; waits for a beat, checks it for 'stall' extra
   // cycles with rsp_ready low, then completes the handshake and returns at
   // the negedge after the handshake edge.
   task automatic recv_beat(input string tag, input logic [15:0] ed, input logic [5:0] er,
                            input logic el, input logic ee, input int elat, input int stall);
      int lat;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".lat"},   32'(lat),       32'(elat));
      for (int s = 0; s <= stall; s++) begin
         if (s > 0) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
         end
         check({tag, ".data"},   32'(rsp_data),   32'(ed));
         check({tag, ".regnum"}, 32'(rsp_regnum), 32'(er));
         check({tag, ".last"},   32'(rsp_last),   32'(el));
         check({tag, ".err"},    32'(rsp_err),    32'(ee));
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   // Single-register request checked against the reference model.
   task automatic do_rw(input logic [1:0] c, input logic [5:0] n, input logic [15:0] d, input int stall);
      bit ok;
      ok = (state == STATE_HALTED) && (int'(n) < NREG);
      send_req(c, n, d);
      if (!ok) begin
         recv_beat("err", 16'd0, n, 1'b1, 1'b1, 1, stall);
      end else if (c == DBG_CMD_WRITE) begin
         ref_rf[n] = d;
         exp_we++;
         recv_beat("write", d, n, 1'b1, 1'b0, 2, stall);
      end else begin
         recv_beat("read", ref_rf[n], n, 1'b1, 1'b0, 2, stall);
      end
      check("we_count", 32'(we_count), 32'(exp_we));
   endtask

   // Full DUMP with a stall pattern taken from stall_mask bit (k % 2).
   task automatic dump_check(input string tag, input logic [1:0] stall_mask);
      send_req(DBG_CMD_DUMP, 6'd0, 16'd0);
      for (int k = 0; k < NREG; k++) begin
         recv_beat(tag, ref_rf[k], 6'(k), (k == NREG - 1), 1'b0, 2, int'(stall_mask[k % 2]));
      end
      check({tag, ".idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int lat;
      int beat;
      logic [1:0]  rc;
      logic [5:0]  rn;
      logic [15:0] rd;

      rst        = 1'b1;
      state      = STATE_HALTED;
      req_valid  = 1'b0;
      req_cmd    = 2'd0;
      req_regnum = 6'd0;
      req_wdata  = 16'd0;
      rsp_ready  = 1'b0;
      for (int k = 0; k < NREG; k++) ref_rf[k] = 16'h0000;

      repeat (2) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;
      @(negedge clk);

      // Preload registers with 0x1000+k, with varying response stalls.
      for (int k = 0; k < NREG; k++) begin
         do_rw(DBG_CMD_WRITE, 6'(k), 16'h1000 + 16'(k), k % 3);
      end

      // Write then read back register 5.
      do_rw(DBG_CMD_WRITE, 6'd5, 16'hBEEF, 0);
      do_rw(DBG_CMD_READ,  6'd5, 16'd0,    0);

      // Not halted: write is refused and register 3 is unchanged.
      state = STATE_HALTED ^ 3'd1;
      do_rw(DBG_CMD_WRITE, 6'd3, 16'h1234, 1);
      state = STATE_HALTED;
      do_rw(DBG_CMD_READ,  6'd3, 16'd0, 0);

      // Register-number range boundaries.
      do_rw(DBG_CMD_READ,  6'd20, 16'd0,    0);
      do_rw(DBG_CMD_WRITE, 6'd16, 16'hDEAD, 0);
      do_rw(DBG_CMD_READ,  6'd15, 16'd0,    0);

      // DUMP with rsp_ready toggling 1,0,1,... (stall on odd beats).
      dump_check("dump_stall", 2'b10);

      // DUMP with rsp_ready held high: last handshake at E0+32.
      send_req(DBG_CMD_DUMP, 6'd0, 16'd0);
      rsp_ready = 1'b1;
      lat  = 1;
      beat = 0;
      while (beat < NREG && lat < 200) begin
         if (rsp_valid === 1'b1) begin
            check("dumpfast.data",   32'(rsp_data),   32'(ref_rf[beat]));
            check("dumpfast.regnum", 32'(rsp_regnum), 32'(beat));
            check("dumpfast.last",   32'(rsp_last),   32'(beat == NREG - 1));
            if (beat == NREG - 1) begin
               check("dumpfast.total", 32'(lat), 32'(2 * NREG));
            end
            beat++;
         end
         @(negedge clk);
         lat++;
      end
      rsp_ready = 1'b0;
      check("dumpfast.beats", 32'(beat), 32'(NREG));
      check("dumpfast.idle",  32'(busy), 32'd0);

      // CLEAR aborted by leaving HALTED after 6 write cycles.
      send_req(DBG_CMD_CLEAR, 6'd0, 16'd0);
      check("clr_abort.we_on", 32'(dbg_reg_we), 32'd1);
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1 state = STATE_HALTED ^ 3'd4;
      @(negedge clk);
      check("clr_abort.we_gate", 32'(dbg_reg_we), 32'd0);
      for (int k = 0; k < 6; k++) ref_rf[k] = 16'h0000;
      exp_we += 6;
      recv_beat("clr_abort", 16'd0, 6'd6, 1'b1, 1'b1, 2, 1);
      check("clr_abort.we_count", 32'(we_count), 32'(exp_we));
      state = STATE_HALTED;
      dump_check("dump_after_abort", 2'b01);

      // Randomized single-register traffic.
      for (int i = 0; i < 40; i++) begin
         state = ($urandom_range(0, 3) == 0) ? (STATE_HALTED ^ 3'($urandom_range(1, 7)))
                                             : STATE_HALTED;
         rc = 2'($urandom_range(0, 1));
         rn = 6'($urandom_range(0, 23));
         rd = 16'($urandom);
         do_rw(rc, rn, rd, $urandom_range(0, 2));
      end
      state = STATE_HALTED;
      dump_check("dump_random", 2'b11);

      // Full CLEAR: NUM_REGS writes, handshake at E0+NUM_REGS+1.
      send_req(DBG_CMD_CLEAR, 6'd0, 16'd0);
      for (int k = 0; k < NREG; k++) ref_rf[k] = 16'h0000;
      exp_we += NREG;
      recv_beat("clr", 16'd0, 6'(NREG - 1), 1'b1, 1'b0, NREG + 1, 0);
      check("clr.we_count", 32'(we_count), 32'(exp_we));
      for (int k = 0; k < NREG; k++) begin
         check("clr.rf", 32'(rf[k]), 32'(ref_rf[k]));
      end

      // Asynchronous reset in the middle of a DUMP at k=7.
      do_rw(DBG_CMD_WRITE, 6'd7, 16'hA5A5, 0);
      send_req(DBG_CMD_DUMP, 6'd0, 16'd0);
      rsp_ready = 1'b1;
      lat = 0;
      while (!(rsp_valid === 1'b1 && rsp_regnum == 6'd7) && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("arst.beat7", 32'(rsp_data), 32'(ref_rf[7]));
      #2 rst = 1'b1;
      #1 check_reset("arst_async");
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_reset("arst_held");
      rst = 1'b0;
      @(negedge clk);
      do_rw(DBG_CMD_READ, 6'd7, 16'd0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
